// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable data width and parity, feeding a
// first-word-fall-through receive FIFO with sticky frame/parity/overrun flags.
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                 state, state_n;
    logic                   rxd_meta, rxd_s;
    logic [CW-1:0]          cyc_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   frame_bad;
    logic                   sample_now, exp_par;
    logic                   cyc_clr, shift_en, bit_inc, par_fail, push_req, frame_set;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   full, push, pop, overrun_set;

    // Both flops reset high so the idle line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // The first sample lands mid start bit; later ones are one full bit apart.
    assign sample_now = (state == S_START) ? (cyc_cnt == HALF_LAST) : (cyc_cnt == BIT_LAST);
    assign exp_par    = (^shreg) ^ (PARITY == 2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_n   = state;
        cyc_clr   = 1'b0;
        shift_en  = 1'b0;
        bit_inc   = 1'b0;
        par_fail  = 1'b0;
        push_req  = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_n = S_START;
                    cyc_clr = 1'b1;
                end
            end
            S_START: begin
                if (sample_now) begin
                    cyc_clr = 1'b1;
                    state_n = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_now) begin
                    cyc_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == DATA_LAST) state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    else                      bit_inc = 1'b1;
                end
            end
            S_PAR: begin
                if (sample_now) begin
                    cyc_clr  = 1'b1;
                    par_fail = (rxd_s != exp_par);
                    state_n  = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_now) begin
                    cyc_clr = 1'b1;
                    if (rxd_s) begin
                        push_req = !frame_bad;
                        state_n  = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxd_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_bad <= 1'b0;
        end else begin
            cyc_cnt <= cyc_clr ? '0 : cyc_cnt + 1'b1;
            if (state == S_IDLE) begin
                bit_cnt   <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (bit_inc)  bit_cnt   <= bit_cnt + 1'b1;
                if (par_fail) frame_bad <= 1'b1;
            end
            if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign full        = (count == DEPTH);
    assign rd_valid    = (count != '0);
    assign pop         = rd_en && rd_valid;
    assign push        = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the storage is reset on purpose so rd_data reads zero after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps its flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_set)        frame_err  <= 1'b1;
            else if (clr_err)     frame_err  <= 1'b0;
            if (par_fail)         parity_err <= 1'b1;
            else if (clr_err)     parity_err <= 1'b0;
            if (overrun_set)      overrun    <= 1'b1;
            else if (clr_err)     overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default 8N1 instance and a 7E1 instance driven with
// directed and random frames, checked against a queue-based receive model.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int CPB0 = 87;
    localparam int CPB1 = 16;
    localparam int DB1  = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #50 clk = ~clk;

    logic       rxd0 = 1'b1, rd_en0 = 1'b0, clr0 = 1'b0;
    logic       rxd1 = 1'b1, rd_en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] rd_data0;
    logic [6:0] rd_data1;
    logic [2:0] count0, count1;
    logic       rd_valid0, frame_err0, parity_err0, overrun0;
    logic       rd_valid1, frame_err1, parity_err1, overrun1;

    uart_rx_fifo dut0 (
        .clk(clk), .resetn(resetn), .rxd(rxd0), .rd_en(rd_en0), .clr_err(clr0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
        .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .resetn(resetn), .rxd(rxd1), .rd_en(rd_en1), .clr_err(clr1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1),
        .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1)
    );

    // Reference model: what each receiver should hold and which flags are up.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit fe[2], pe[2], ov[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_dut(input int sel, input string tag);
        int         n;
        logic [7:0] head, data;
        logic [2:0] cnt;
        logic       valid, f, p, o;
        head = 8'h00;
        if (sel == 0) begin
            n = q0.size(); if (n != 0) head = q0[0];
            valid = rd_valid0; cnt = count0; data = rd_data0;
            f = frame_err0; p = parity_err0; o = overrun0;
        end else begin
            n = q1.size(); if (n != 0) head = q1[0];
            valid = rd_valid1; cnt = count1; data = {1'b0, rd_data1};
            f = frame_err1; p = parity_err1; o = overrun1;
        end
        check({tag, " rd_valid"},   32'(valid), 32'(n != 0));
        check({tag, " count"},      32'(cnt),   32'(n));
        if (n != 0) check({tag, " rd_data"}, 32'(data), 32'(head));
        check({tag, " frame_err"},  32'(f), 32'(fe[sel]));
        check({tag, " parity_err"}, 32'(p), 32'(pe[sel]));
        check({tag, " overrun"},    32'(o), 32'(ov[sel]));
    endtask

    task automatic drive_rxd(input int sel, input logic v);
        if (sel == 0) rxd0 = v; else rxd1 = v;
    endtask

    task automatic drive_rd_en(input int sel, input logic v);
        if (sel == 0) rd_en0 = v; else rd_en1 = v;
    endtask

    // par: 0 none, 1 correct even parity, 2 wrong parity. low_tail extends the
    // line low after the stop bit by whole bit times. pop_at pulses rd_en on
    // that falling edge (counted from the start-bit edge), or never if < 0.
    task automatic send_frame(input int sel, input logic [7:0] data, input int par,
                              input logic stop_bit, input int low_tail, input int pop_at);
        int   cpb, nd, m;
        logic p;
        logic bits[$];
        cpb = (sel == 0) ? CPB0 : CPB1;
        nd  = (sel == 0) ? 8 : DB1;
        p   = 1'b0;
        m   = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(data[i]);
            p ^= data[i];
        end
        if (par == 1) bits.push_back(p);
        else if (par == 2) bits.push_back(~p);
        bits.push_back(stop_bit);
        for (int i = 0; i < low_tail; i++) bits.push_back(1'b0);
        @(negedge clk);
        foreach (bits[i]) begin
            drive_rxd(sel, bits[i]);
            repeat (cpb) begin
                if (m == pop_at)     drive_rd_en(sel, 1'b1);
                if (m == pop_at + 1) drive_rd_en(sel, 1'b0);
                @(negedge clk);
                m++;
            end
        end
        drive_rxd(sel, 1'b1);
        drive_rd_en(sel, 1'b0);
    endtask

    // Frame outcome from the receive rules: bad stop or bad parity drops the
    // byte; a good byte is stored if there is room or a pop happens alongside.
    task automatic expect_frame(input int sel, input logic [7:0] data, input bit good_par,
                                input logic stop_bit, input bit pop_same);
        logic [7:0] d;
        int n;
        d = (sel == 0) ? data : (data & 8'h7F);
        n = (sel == 0) ? q0.size() : q1.size();
        if (!good_par) pe[sel] = 1'b1;
        if (!stop_bit) fe[sel] = 1'b1;
        else if (good_par) begin
            if (pop_same && n != 0) begin
                if (sel == 0) begin void'(q0.pop_front()); q0.push_back(d); end
                else          begin void'(q1.pop_front()); q1.push_back(d); end
            end else if (n < 4) begin
                if (sel == 0) q0.push_back(d); else q1.push_back(d);
            end else ov[sel] = 1'b1;
        end
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        drive_rd_en(sel, 1'b1);
        @(negedge clk);
        drive_rd_en(sel, 1'b0);
        if (sel == 0 && q0.size() != 0) void'(q0.pop_front());
        if (sel == 1 && q1.size() != 0) void'(q1.pop_front());
    endtask

    task automatic clear_flags(input int sel);
        @(negedge clk);
        if (sel == 0) clr0 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
        fe[sel] = 1'b0; pe[sel] = 1'b0; ov[sel] = 1'b0;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin fe[i] = 1'b0; pe[i] = 1'b0; ov[i] = 1'b0; end
    endtask

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         gp;
        int         pop_at;

        model_reset();
        repeat (5) @(negedge clk);
        check("reset rd_data0", 32'(rd_data0), 32'h0);
        check("reset rd_data1", 32'(rd_data1), 32'h0);
        check_dut(0, "reset0");
        check_dut(1, "reset1");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 8N1 byte, then a single pop.
        send_frame(0, 8'h3F, 0, 1'b1, 0, -1);
        expect_frame(0, 8'h3F, 1'b1, 1'b1, 1'b0);
        check_dut(0, "rx_3f");
        pop(0);
        check_dut(0, "pop_3f");

        // 20-cycle glitch must be rejected as a false start.
        @(negedge clk);
        rxd0 = 1'b0;
        repeat (20) @(negedge clk);
        rxd0 = 1'b1;
        repeat (2 * CPB0) @(negedge clk);
        check_dut(0, "glitch");

        // Stop bit low for two bit times, then a good byte and a flag clear.
        send_frame(0, 8'hA5, 0, 1'b0, 1, -1);
        expect_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        check_dut(0, "frame_err");
        repeat (CPB0) @(negedge clk);
        send_frame(0, 8'h12, 0, 1'b1, 0, -1);
        expect_frame(0, 8'h12, 1'b1, 1'b1, 1'b0);
        check_dut(0, "after_break");
        clear_flags(0);
        check_dut(0, "clr_frame");
        pop(0);

        // Even parity on the 7E1 instance: wrong then right parity bit.
        send_frame(1, 8'h07, 2, 1'b1, 0, -1);
        expect_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
        check_dut(1, "par_bad");
        send_frame(1, 8'h07, 1, 1'b1, 0, -1);
        expect_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
        check_dut(1, "par_good");
        clear_flags(1);
        pop(1);
        check_dut(1, "par_drain");

        // Five back-to-back bytes into a 4-deep FIFO.
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 8'(v), 0, 1'b1, 0, -1);
            expect_frame(0, 8'(v), 1'b1, 1'b1, 1'b0);
        end
        check_dut(0, "overrun");
        for (int i = 0; i < 4; i++) begin
            check_dut(0, "drain");
            pop(0);
        end
        check_dut(0, "drained");
        clear_flags(0);

        // Fill the 7E1 FIFO, then pop in the very cycle the next byte is pushed.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 127));
            send_frame(1, d, 1, 1'b1, 0, -1);
            expect_frame(1, d, 1'b1, 1'b1, 1'b0);
        end
        check_dut(1, "full1");
        // Push edge sits H + (1+DATA_BITS+1) bit times after detect; detect is
        // three falling edges after the start-bit edge, so pulse on the one before.
        pop_at = CPB1 / 2 + (1 + DB1 + 1) * CPB1 + 2;
        d = 8'($urandom_range(0, 127));
        send_frame(1, d, 1, 1'b1, 0, pop_at);
        expect_frame(1, d, 1'b1, 1'b1, 1'b1);
        check_dut(1, "push_pop_full");
        d = 8'($urandom_range(0, 127));
        send_frame(1, d, 1, 1'b1, 0, -1);
        expect_frame(1, d, 1'b1, 1'b1, 1'b0);
        check_dut(1, "overrun1");
        for (int i = 0; i < 4; i++) pop(1);
        clear_flags(1);
        check_dut(1, "empty1");

        // Random traffic with random reads on both instances.
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) pop(0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            d = 8'($urandom);
            send_frame(0, d, 0, 1'b1, 0, -1);
            expect_frame(0, d, 1'b1, 1'b1, 1'b0);
            check_dut(0, "rand0");
        end
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) != 0) pop(1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            d  = 8'($urandom_range(0, 127));
            gp = ($urandom_range(0, 3) != 0);
            send_frame(1, d, gp ? 1 : 2, 1'b1, 0, -1);
            expect_frame(1, d, gp, 1'b1, 1'b0);
            check_dut(1, "rand1");
        end

        // Reset in the middle of a data bit with two bytes buffered.
        while (q0.size() != 0) pop(0);
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            send_frame(0, d, 0, 1'b1, 0, -1);
            expect_frame(0, d, 1'b1, 1'b1, 1'b0);
        end
        check_dut(0, "two_buffered");
        @(negedge clk);
        rxd0 = 1'b0;
        repeat (CPB0 + CPB0 / 2) @(negedge clk);
        rxd0 = 1'b1;
        repeat (CPB0) @(negedge clk);
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rxd0 = 1'b0;
        resetn = 1'b1;
        repeat (CPB0 / 2) @(negedge clk);
        rxd0 = 1'b1;
        repeat (2 * CPB0) @(negedge clk);
        check("mid_reset rd_data0", 32'(rd_data0), 32'h0);
        check_dut(0, "mid_reset0");
        check_dut(1, "mid_reset1");
        send_frame(0, 8'h5A, 0, 1'b1, 0, -1);
        expect_frame(0, 8'h5A, 1'b1, 1'b1, 1'b0);
        check_dut(0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated first-word-fall-through receive FIFO, replacing the fixed 8N1 receive path in the SOC's UART peripheral. It oversamples the asynchronous `rxd` line, supports configurable data width and parity, and discards bad frames while flagging them. Good bytes are buffered so the rv32i core can read them by polling without losing back-to-back characters.

## Interface
- `CLKS_PER_BIT`, 87, clock cycles per UART bit (10 MHz / 115200 baud); must be ≥ 4.
- `DATA_BITS`, 8, data bits per frame, 5..8.
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pop the FIFO head; ignored while `rd_valid` = 0.
- `clr_err`  in  1  clears all sticky error flags.
- `rd_data`  out  DATA_BITS  FIFO head; valid while `rd_valid` = 1.
- `rd_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `parity_err`  out  1  sticky: parity mismatch.
- `overrun`  out  1  sticky: good byte arrived while FIFO full.

## Operation
- Two-flop synchroniser on `rxd`; both flops reset to 1.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: synchronised `rxd` = 0 → START; the bit counter and cycle counter are cleared.
- Sample points are counted from the detect cycle D. Sample k is taken at cycle D + H + k·CLKS_PER_BIT, where H = CLKS_PER_BIT/2 (integer division).
  - k = 0 is the start bit.
  - k = 1..DATA_BITS are the data bits, LSB first, shifted into the shift register.
  - Next comes the parity bit, present only if PARITY ≠ 0.
  - The last sample is the stop bit.
- START sample = 1: false start; return to IDLE and record nothing.
- PAR: compute the expected bit (even: XOR of the data bits; odd: its inverse). A mismatch sets `parity_err` and marks the frame bad.
- STOP sample = 1:
  - Frame good, FIFO not full → push.
  - Frame good, FIFO full, no pop this cycle → drop the byte and set `overrun`.
  - Frame bad → drop the byte.
  - In all three cases, go to IDLE immediately, which allows a start edge from mid-stop onward.
- STOP sample = 0: set `frame_err`, drop the byte, go to WAIT_HIGH. WAIT_HIGH → IDLE when synchronised `rxd` = 1 (break handling).
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. `rd_data` = mem[rd_ptr], combinational.
  - Push and pop in the same cycle while full: both occur, `count` unchanged, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect.
- `clr_err` clears all three sticky flags. If `clr_err` and a new error event occur in the same cycle, the set wins.
- Reset state: all states IDLE, counters 0, pointers 0, `rd_valid` = 0, `count` = 0, all error flags 0, `rd_data` = 0 (memory cleared).
- `resetn` asserted mid-frame: the partial frame is lost; the block resumes at IDLE with the FIFO empty.

## Timing
- `rxd` falling at the input pin → detect cycle D two or three `clk` edges later (synchroniser).
- Push in cycle D + H + (1 + DATA_BITS + P)·CLKS_PER_BIT, where P = 1 if parity is enabled, else 0. For 8N1 with defaults this is D + 826.
- `rd_valid` and `count` update on the edge after the push. Sticky flags assert on the edge after their sample point.
- `rd_en` with `rd_valid` = 1 pops on that edge; the next head appears the following cycle.
- Sustained input at full baud rate cannot overflow the FSM: the next start edge is detectable from the stop-bit sample onward.

## Test plan
- Reset, then send 0x3F as 8N1 at 8700 ns per bit with defaults → `rd_valid` = 1, `rd_data` = 0x3F, `count` = 1, no flags; then pulse `rd_en` for 1 cycle → `count` = 0, `rd_valid` = 0.
- Drive a 20-cycle low glitch on `rxd` → no push, state back to IDLE, no flags.
- Send 0xA5 with the stop bit driven 0 and held low for 2 bit times → `frame_err` = 1, `count` = 0; a following good byte 0x12 → `count` = 1, `rd_data` = 0x12; `clr_err` → `frame_err` = 0.
- With PARITY = 1, send 0x07 with the parity bit = 0 (expected 1) → `parity_err` = 1, no push; then 0x07 with parity bit = 1 → push 0x07.
- With FIFO_DEPTH = 4, send 0x01..0x05 back-to-back with no reads → `count` = 4, `overrun` = 1; four pops return 0x01..0x04 in order.
- Assert `resetn` low at mid-data-bit of a frame while 2 bytes are buffered → `count` = 0, `rd_valid` = 0, flags 0; the next full frame 0x5A is received correctly.
